// File: rtl/sprite_blitter_pkg.sv
// Shared definitions for the sprite blitter: screen geometry, FSM encoding
// and the fixed per-byte cycle cost.
package sprite_blitter_pkg;

  localparam int LORES_W     = 64;
  localparam int LORES_H     = 32;
  localparam int HIRES_W     = 128;
  localparam int HIRES_H     = 64;
  localparam int BYTE_CYCLES = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_PRD,
    ST_PWR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sprite_blitter_blit_coord.sv
// Maps a sprite-relative (row, col) onto a screen pixel and flags pixels that
// fall off the right or bottom edge; the sprite body never wraps.
module sprite_blitter_blit_coord
  import sprite_blitter_pkg::*;
(
  input  logic [6:0] ox,
  input  logic [5:0] oy,
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic       hires,
  output logic [6:0] hpos,
  output logic [5:0] vpos,
  output logic       clip
);

  logic [7:0] h_sum;
  logic [6:0] v_sum;

  assign h_sum = {1'b0, ox} + {4'b0000, col};
  assign v_sum = {1'b0, oy} + {3'b000, row};
  assign hpos  = h_sum[6:0];
  assign vpos  = v_sum[5:0];

  always_comb begin
    clip = 1'b0;
    if (hires) clip = (h_sum >= 8'(HIRES_W)) || (v_sum >= 7'(HIRES_H));
    else       clip = (h_sum >= 8'(LORES_W)) || (v_sum >= 7'(LORES_H));
  end

endmodule

// File: rtl/sprite_blitter.sv
// DXYN draw engine: fetches sprite bytes, XORs them into vram pixel by pixel
// and reports whether any lit pixel was turned off.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        x,
  input  logic [5:0]        y,
  input  logic [3:0]        n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              hires,
  input  logic [1:0]        plane_mask,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_dout,
  output logic [6:0]        vram_hpos,
  output logic [5:0]        vram_vpos,
  input  logic [1:0]        vram_pixelo,
  output logic [1:0]        vram_pixeli,
  output logic              vram_we,
  output state_t            dbg_state
);

  // Handshake: start is a single-cycle request honoured only while busy=0;
  // done pulses for one cycle on the same edge that busy falls.

  state_t     state;
  logic [6:0] ox;
  logic [5:0] oy;
  logic       hires_q;
  logic       wide_q;
  logic [3:0] rows_m1;
  logic [1:0] mask_q;
  logic       plane;
  logic [3:0] row;
  logic       byte_col;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic       clip;

  assign dbg_state = state;

  sprite_blitter_blit_coord u_coord (
    .ox    (ox),
    .oy    (oy),
    .row   (row),
    .col   ({byte_col, bit_idx}),
    .hires (hires_q),
    .hpos  (vram_hpos),
    .vpos  (vram_vpos),
    .clip  (clip)
  );

  // The write is combinational in PWR because vram_pixelo only becomes valid
  // there; coordinates stay stable across PRD/PWR so the write hits the read.
  assign vram_we     = (state == ST_PWR) && sh[7] && !clip;
  assign vram_pixeli = (state == ST_PWR) ? (vram_pixelo ^ (plane ? 2'b10 : 2'b01)) : 2'b00;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      ram_addr  <= '0;
      ox        <= '0;
      oy        <= '0;
      hires_q   <= 1'b0;
      wide_q    <= 1'b0;
      rows_m1   <= '0;
      mask_q    <= 2'b01;
      plane     <= 1'b0;
      row       <= '0;
      byte_col  <= 1'b0;
      bit_idx   <= '0;
      sh        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ox        <= hires ? x : {1'b0, x[5:0]};
            oy        <= hires ? y : {1'b0, y[4:0]};
            hires_q   <= hires;
            wide_q    <= hires && (n == 4'd0);
            rows_m1   <= n - 4'd1;
            mask_q    <= (plane_mask == 2'b00) ? 2'b01 : plane_mask;
            plane     <= (plane_mask == 2'b10);
            row       <= '0;
            byte_col  <= 1'b0;
            bit_idx   <= '0;
            ram_addr  <= i_addr;
            collision <= 1'b0;
            busy      <= 1'b1;
            state     <= (!hires && (n == 4'd0)) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          sh    <= ram_dout;
          state <= ST_PRD;
        end
        ST_PRD: state <= ST_PWR;
        ST_PWR: begin
          if (vram_we && vram_pixelo[plane]) collision <= 1'b1;
          if (bit_idx != 3'd7) begin
            bit_idx <= bit_idx + 3'd1;
            sh      <= {sh[6:0], 1'b0};
            state   <= ST_PRD;
          end else begin
            bit_idx  <= '0;
            ram_addr <= ram_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            state    <= ST_FETCH;
            if (wide_q && !byte_col) begin
              byte_col <= 1'b1;
            end else begin
              byte_col <= 1'b0;
              if (row != rows_m1) begin
                row <= row + 4'd1;
              end else begin
                row <= '0;
                if (!plane && (mask_q == 2'b11)) plane <= 1'b1;
                else                            state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ram/vram models, a reference draw model
// feeding an expected queue, and a final tally.
module tb_sprite_blitter;
  import sprite_blitter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  x = '0;
  logic [5:0]  y = '0;
  logic [3:0]  n = '0;
  logic [15:0] i_addr = '0;
  logic        hires = 1'b0;
  logic [1:0]  plane_mask = '0;
  logic        busy, done, collision, vram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout = '0;
  logic [6:0]  vram_hpos;
  logic [5:0]  vram_vpos;
  logic [1:0]  vram_pixelo = '0;
  logic [1:0]  vram_pixeli;
  state_t      dbg_state;

  sprite_blitter #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .n(n),
    .i_addr(i_addr), .hires(hires), .plane_mask(plane_mask),
    .busy(busy), .done(done), .collision(collision), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .vram_hpos(vram_hpos), .vram_vpos(vram_vpos),
    .vram_pixelo(vram_pixelo), .vram_pixeli(vram_pixeli), .vram_we(vram_we),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram_mem  [0:65535];
  logic [1:0]  vram_mem [0:8191];
  logic [1:0]  exp_vram [0:8191];
  logic [31:0] exp_lat_q[$];
  logic [31:0] exp_coll_q[$];
  logic        clr_req = 1'b0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          stray_we = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ram_dout <= ram_mem[ram_addr];
    vram_pixelo <= vram_mem[{vram_vpos, vram_hpos}];
    if (clr_req) begin
      for (int k = 0; k < 8192; k++) vram_mem[k] <= 2'b00;
    end else if (vram_we) begin
      vram_mem[{vram_vpos, vram_hpos}] <= vram_pixeli;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (vram_we && (!busy || dbg_state != ST_PWR)) stray_we++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_all();
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 0; k < 8192; k++) exp_vram[k] = 2'b00;
  endtask

  // Reference: straightforward nested loops over planes, rows, bytes, bits.
  task automatic ref_draw(input logic [6:0] xx, input logic [5:0] yy, input logic [3:0] nn,
                          input logic [15:0] ia, input logic hr, input logic [1:0] pm);
    int w, h, ox, oy, rows, wb, bytes, hp, vp;
    logic [15:0] a;
    logic [1:0]  m;
    logic [7:0]  d;
    logic        c;
    w = hr ? 128 : 64;
    h = hr ? 64 : 32;
    ox = int'(xx) % w;
    oy = int'(yy) % h;
    bytes = 0;
    c = 1'b0;
    if (hr || nn != 4'd0) begin
      rows = (nn == 4'd0) ? 16 : int'(nn);
      wb = (hr && nn == 4'd0) ? 2 : 1;
      m = (pm == 2'b00) ? 2'b01 : pm;
      a = ia;
      for (int p = 0; p < 2; p++) begin
        if (m[p]) begin
          for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < wb; b++) begin
              d = ram_mem[a];
              a = a + 16'd1;
              bytes++;
              for (int k = 0; k < 8; k++) begin
                if (d[7-k]) begin
                  hp = ox + b*8 + k;
                  vp = oy + r;
                  if (hp < w && vp < h) begin
                    if (exp_vram[vp*128+hp][p]) c = 1'b1;
                    exp_vram[vp*128+hp][p] = ~exp_vram[vp*128+hp][p];
                  end
                end
              end
            end
          end
        end
      end
    end
    exp_lat_q.push_back(32'(1 + BYTE_CYCLES*bytes));
    exp_coll_q.push_back({31'd0, c});
  endtask

  task automatic run_draw(input string tag, input logic [6:0] xx, input logic [5:0] yy,
                          input logic [3:0] nn, input logic [15:0] ia, input logic hr,
                          input logic [1:0] pm, input bit poke);
    int c0, k, diffs;
    logic [31:0] el, ec;
    ref_draw(xx, yy, nn, ia, hr, pm);
    @(negedge clk);
    x = xx; y = yy; n = nn; i_addr = ia; hires = hr; plane_mask = pm;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c0 = cyc;
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    k = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
      if (poke && k == 4) begin
        start = 1'b1;
        x = x + 7'd5;
        n = 4'd3;
      end
      if (poke && k == 5) start = 1'b0;
    end
    if (!done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    el = exp_lat_q.pop_front();
    ec = exp_coll_q.pop_front();
    check({tag, "_latency"}, 32'(cyc - c0), el);
    check({tag, "_collision"}, {31'd0, collision}, ec);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_collision_held"}, {31'd0, collision}, ec);
    diffs = 0;
    for (int j = 0; j < 8192; j++) if (vram_mem[j] !== exp_vram[j]) diffs++;
    check({tag, "_vram_image"}, 32'(diffs), 32'd0);
  endtask

  function automatic logic [31:0] pix(input int hp, input int vp);
    return {30'd0, vram_mem[vp*128+hp]};
  endfunction

  initial begin
    int w0;
    for (int k = 0; k < 65536; k++) ram_mem[k] = 8'h00;
    ram_mem[16'h0200] = 8'hF0;
    ram_mem[16'h0300] = 8'hFF;
    ram_mem[16'h0301] = 8'hFF;
    for (int k = 0; k < 32; k++) ram_mem[16'h0400 + k] = 8'hFF;
    ram_mem[16'h0500] = 8'h80;
    ram_mem[16'h0501] = 8'h80;
    ram_mem[16'hFFFF] = 8'hAA;
    ram_mem[16'h0000] = 8'h55;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_collision", {31'd0, collision}, 32'd0);
    check("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    check("rst_vram_we", {31'd0, vram_we}, 32'd0);
    reset = 1'b1;
    clear_all();

    run_draw("d1_basic", 7'd2, 6'd3, 4'd1, 16'h0200, 1'b0, 2'b01, 1'b0);
    check("d1_pix_2_3", pix(2, 3), 32'd1);
    check("d1_pix_5_3", pix(5, 3), 32'd1);
    check("d1_pix_6_3", pix(6, 3), 32'd0);

    run_draw("d2_erase", 7'd2, 6'd3, 4'd1, 16'h0200, 1'b0, 2'b01, 1'b0);
    check("d2_pix_2_3", pix(2, 3), 32'd0);

    run_draw("d_lores_n0", 7'd5, 6'd5, 4'd0, 16'h0200, 1'b0, 2'b00, 1'b0);

    run_draw("d3_corner", 7'd62, 6'd31, 4'd2, 16'h0300, 1'b0, 2'b01, 1'b1);
    check("d3_pix_62_31", pix(62, 31), 32'd1);
    check("d3_pix_63_31", pix(63, 31), 32'd1);
    check("d3_pix_0_31", pix(0, 31), 32'd0);
    check("d3_pix_62_0", pix(62, 0), 32'd0);

    clear_all();
    run_draw("d4_hires16", 7'(200), 6'(70), 4'd0, 16'h0400, 1'b1, 2'b01, 1'b0);
    check("d4_pix_72_6", pix(72, 6), 32'd1);
    check("d4_pix_87_21", pix(87, 21), 32'd1);
    check("d4_pix_88_6", pix(88, 6), 32'd0);
    check("d4_pix_72_22", pix(72, 22), 32'd0);

    clear_all();
    run_draw("d5_planes", 7'd0, 6'd0, 4'd1, 16'h0500, 1'b0, 2'b11, 1'b0);
    check("d5_pix_0_0", pix(0, 0), 32'd3);

    run_draw("d6_addr_wrap", 7'd10, 6'd10, 4'd1, 16'hFFFF, 1'b0, 2'b11, 1'b0);

    clear_all();
    @(negedge clk);
    x = 7'd0; y = 6'd0; n = 4'd0; i_addr = 16'h0400; hires = 1'b1; plane_mask = 2'b01;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    w0 = wr_cnt;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ram_addr", {16'd0, ram_addr}, 32'd0);
    check("abort_hpos", {25'd0, vram_hpos}, 32'd0);
    check("abort_pixeli", {30'd0, vram_pixeli}, 32'd0);
    check("abort_we", {31'd0, vram_we}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("abort_still_idle", {31'd0, busy}, 32'd0);

    check("stray_we", 32'(stray_we), 32'd0);
    check("queue_drained", 32'(exp_lat_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
